seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the sequence detector; converts WIDTH-bit words into the one-bit-per-clock stream the detector samples on its `in` input.
- Accepts words over a valid/ready handshake.
- Holds one word in a skid buffer while another shifts, so consecutive words stream with no idle gap.
- Drives 0 on the serial line when idle, so the detector sees a quiet line.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  WIDTH  parallel word to serialize.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit; connects to the detector's in.
- ser_valid  output  1  ser_out carries a real data bit this cycle.
- frame_done  output  1  one-cycle pulse coincident with the last bit of a word.
- busy  output  1  word in shift register or buffer.

Behaviour:
- Reset (async assert, release synchronous to clk), outputs and state:
  - ser_out=0, ser_valid=0, frame_done=0, busy=0, data_ready=1.
  - FSM=IDLE, bit counter=0, buffer empty.
- Handshake:
  - Transfer occurs on a rising edge where data_valid=1 and data_ready=1.
  - data_ready = !buf_full; it is purely a function of registered state, with no combinational path from data_valid.
  - data_in is ignored when no transfer occurs.
- FSM states:
  - IDLE (shift register empty).
  - SHIFT (bit counter 0..WIDTH-1 in flight).
- IDLE + transfer: the word loads directly into the shift register (buffer bypassed).
  - Next cycle: ser_valid=1, ser_out=first bit, counter=0, go to SHIFT.
  - Latency from accept edge to first bit: 1 cycle.
- SHIFT behaviour:
  - Each edge advances one bit and increments the counter.
  - Bits appear on WIDTH consecutive cycles.
  - Bit order is set by MSB_FIRST.
- SHIFT + transfer while buffer empty: the word goes to the buffer (buf_full=1, data_ready drops the next cycle).
- Last bit (counter==WIDTH-1): frame_done=1 for exactly that cycle. At the following edge, in priority order:
  1. Buffer full: load the buffer into the shift register and clear the buffer. Stay in SHIFT with counter=0. No gap cycle: the next word's first bit follows the previous last bit immediately.
  2. Buffer empty and a transfer occurs on that same edge: load data_in directly into the shift register. Stay in SHIFT with no gap.
  3. Otherwise: go to IDLE; ser_valid=0, ser_out=0.
- Idle line: ser_out is forced to 0 whenever ser_valid=0.
- busy: busy = (FSM==SHIFT) | buf_full.
- Counter width: $clog2(WIDTH). It wraps to 0 only on reload; no other wrap.
- Reset mid-word:
  - The in-flight word and buffered word are discarded.
  - ser_out drops to 0 immediately (async).
  - No frame_done is emitted.
- The block never back-pressures the serial side; the detector must consume every bit.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1: after reset, present 8'hB5 for one accepting edge -> ser_out reads 1,0,1,1,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept. frame_done high only on the 8th bit. Then ser_valid=0 and ser_out=0.
- Bit order, MSB_FIRST=0: load 8'hB5 -> ser_out reads 1,0,1,0,1,1,0,1.
- Back-to-back streaming: hold data_valid=1 with 8'hB5, then 8'h0F, then 8'hA0.
  - Required: 24 contiguous ser_valid cycles with no gap.
  - data_ready low from the cycle after the 2nd word is accepted until the edge where that word moves into the shift register.
  - frame_done pulses on cycles 8, 16, 24.
- Simultaneous last-bit and accept with empty buffer: present the second word exactly on the last-bit edge of the first -> no idle cycle between words; buffer stays empty.
- Reset mid-operation: assert rst at bit 3 of 8'hFF with a word buffered.
  - ser_out=0 and busy=0 immediately, data_ready=1.
  - After release, a new word 8'h81 serializes cleanly as 1,0,0,0,0,0,0,1.
- Idle stability: data_valid=0 for 20 cycles after reset -> ser_out=0, ser_valid=0, frame_done=0 throughout.

Source files
------------

// File: rtl/seq_bit_serializer.sv
// Parallel-in/serial-out stage feeding the sequence detector: WIDTH-bit words in over valid/ready,
// one bit per clock out, with a one-word skid buffer so back-to-back words stream gap-free.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;

  logic             xfer;
  logic             cur_bit;
  logic             last_bit;
  logic [WIDTH-1:0] shreg_adv;

  // Handshake: a word moves on a rising edge where data_valid and data_ready are both high.
  // data_ready depends only on registered state, never on data_valid.
  assign data_ready = !buf_full_q;
  assign xfer       = data_valid && data_ready;

  assign cur_bit   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_adv = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST_CNT);

  assign ser_valid  = (state_q == SHIFT);
  assign ser_out    = ser_valid && cur_bit;
  assign frame_done = last_bit;
  assign busy       = (state_q == SHIFT) || buf_full_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          shreg_d = data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          shreg_d = shreg_adv;
          cnt_d   = cnt_q + 1'b1;
          if (xfer) begin
            buf_d      = data_in;
            buf_full_d = 1'b1;
          end
        end else if (buf_full_q) begin
          // Buffered word takes priority; a full buffer also means no transfer this edge.
          shreg_d    = buf_q;
          buf_full_d = 1'b0;
          cnt_d      = '0;
        end else if (xfer) begin
          shreg_d = data_in;
          cnt_d   = '0;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: per-cycle vector tables for streaming cases plus
// hand-written sequences for idle stability and mid-word reset.
module tb_seq_bit_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready, ser_out, ser_valid, frame_done, busy;
  logic       data_ready_l, ser_out_l, ser_valid_l, frame_done_l, busy_l;

  int total;
  int bad;
  logic [0:0] exp_q[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       sv;
    logic       so;
    logic       fd;
    logic       bsy;
    logic       chk_l;
    logic       so_l;
  } vec_t;

  vec_t tbl[$];

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_done(frame_done), .busy(busy)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
    .frame_done(frame_done_l), .busy(busy_l)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int idx, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %b want %b", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rdy,
                              input logic sv, input logic so, input logic fd, input logic bsy);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.sv = sv; r.so = so; r.fd = fd; r.bsy = bsy;
    r.chk_l = 1'b0; r.so_l = 1'b0;
    return r;
  endfunction

  // Driver: each row's outputs are checked at the negedge, then its inputs are applied.
  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      check({nm, ".ready"}, i, data_ready, tbl[i].rdy);
      check({nm, ".ser_valid"}, i, ser_valid, tbl[i].sv);
      check({nm, ".ser_out"}, i, ser_out, tbl[i].so);
      check({nm, ".frame_done"}, i, frame_done, tbl[i].fd);
      check({nm, ".busy"}, i, busy, tbl[i].bsy);
      if (tbl[i].chk_l) begin
        check({nm, ".lsb_ser_out"}, i, ser_out_l, tbl[i].so_l);
        check({nm, ".lsb_frame_done"}, i, frame_done_l, tbl[i].fd);
      end
      data_valid = tbl[i].v;
      data_in    = tbl[i].d;
    end
    tbl.delete();
  endtask

  initial begin
    logic [7:0] seq_m, seq_l, seq_a, seq_b;
    logic [0:0] e;
    vec_t r;
    total = 0;
    bad = 0;
    rst = 1'b1;
    data_valid = 1'b0;
    data_in = 8'h00;

    // Reset state
    @(negedge clk);
    check("rst.ser_out", 0, ser_out, 1'b0);
    check("rst.ser_valid", 0, ser_valid, 1'b0);
    check("rst.frame_done", 0, frame_done, 1'b0);
    check("rst.busy", 0, busy, 1'b0);
    check("rst.ready", 0, data_ready, 1'b1);
    check("rst.lsb_ser_out", 0, ser_out_l, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle stability with random, never-valid data
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle.ser_out", i, ser_out, 1'b0);
      check("idle.ser_valid", i, ser_valid, 1'b0);
      check("idle.frame_done", i, frame_done, 1'b0);
      data_valid = 1'b0;
      data_in = 8'($urandom_range(0, 255));
    end

    // Single word 8'hB5 on both bit orders
    seq_m = 8'b10110101;
    seq_l = 8'b10101101;
    tbl.push_back(mk(1'b1, 8'hB5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      r = mk(1'b0, 8'h5A, 1'b1, 1'b1, seq_m[7-i], (i == 7), 1'b1);
      r.chk_l = 1'b1;
      r.so_l = seq_l[7-i];
      tbl.push_back(r);
    end
    r = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    r.chk_l = 1'b1;
    tbl.push_back(r);
    tbl.push_back(r);
    run_table("single");

    // Back-to-back B5, 0F, A0 with data_valid held high
    tbl.push_back(mk(1'b1, 8'hB5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 8'hA0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    run_table("b2b");

    // Second word offered exactly on the first word's last-bit edge; buffer must stay empty
    seq_a = 8'b00111100;
    seq_b = 8'b11000011;
    tbl.push_back(mk(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk((i == 7), (i == 7) ? 8'hC3 : 8'h00, 1'b1, 1'b1, seq_a[7-i], (i == 7), 1'b1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, seq_b[7-i], (i == 7), 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    run_table("lastacc");

    // Reset at bit 3 of 8'hFF with 8'h55 buffered
    @(negedge clk);
    data_valid = 1'b1;
    data_in = 8'hFF;
    @(negedge clk);
    data_in = 8'h55;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst.pre_busy", 0, busy, 1'b1);
    check("midrst.pre_ready", 0, data_ready, 1'b0);
    check("midrst.pre_ser_out", 0, ser_out, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst.ser_out", 0, ser_out, 1'b0);
    check("midrst.ser_valid", 0, ser_valid, 1'b0);
    check("midrst.busy", 0, busy, 1'b0);
    check("midrst.ready", 0, data_ready, 1'b1);
    check("midrst.frame_done", 0, frame_done, 1'b0);
    @(negedge clk);
    check("midrst.hold_frame_done", 0, frame_done, 1'b0);
    rst = 1'b0;

    // Scoreboard: expected 8'h81 bit stream after reset release
    @(negedge clk);
    check("post.idle_valid", 0, ser_valid, 1'b0);
    data_valid = 1'b1;
    data_in = 8'h81;
    exp_q.push_back(1'b1);
    for (int i = 0; i < 6; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      data_valid = 1'b0;
      e = exp_q.pop_front();
      check("post.ser_valid", i, ser_valid, 1'b1);
      check("post.ser_out", i, ser_out, e[0]);
      check("post.frame_done", i, frame_done, (i == 7));
    end
    @(negedge clk);
    check("post.end_valid", 0, ser_valid, 1'b0);
    check("post.end_busy", 0, busy, 1'b0);
    check("post.end_ser_out", 0, ser_out, 1'b0);

    // Report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
